// File: rtl/column_drop_controller.sv
// column_drop_controller: accepts one column request at a time, drops the
// current player's piece into the lowest empty row of that column, toggles the
// turn and tracks move count / board-full for display and game control.
// Optional single-level undo is enabled by defining COLUMN_DROP_UNDO_EN.
module column_drop_controller #(
  parameter int unsigned ROWS  = 6,
  parameter int unsigned COLS  = 7,
  parameter int unsigned COL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   new_game,
  input  logic                   col_valid,
  input  logic [COL_W-1:0]       col_idx,
`ifdef COLUMN_DROP_UNDO_EN
  input  logic                   undo_req,
  output logic                   undo_ack,
`endif
  output logic                   col_ready,
  output logic                   move_ack,
  output logic                   move_reject,
  output logic                   cur_player,
  output logic [ROWS*COLS-1:0]   board_p1,
  output logic [ROWS*COLS-1:0]   board_p2,
  output logic [2:0]             last_row,
  output logic [COL_W-1:0]       last_col,
  output logic [5:0]             move_count,
  output logic                   board_full
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned HGT_W = 3;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PLACE,
    S_FULL
  } state_e;

  state_e                 state_q;
  logic [COL_W-1:0]       col_q;
  logic [HGT_W-1:0]       height_q [COLS];
  logic [CELLS-1:0]       board_p1_q;
  logic [CELLS-1:0]       board_p2_q;
  logic                   cur_player_q;
  logic                   move_ack_q;
  logic                   move_reject_q;
  logic [2:0]             last_row_q;
  logic [COL_W-1:0]       last_col_q;
  logic [CNT_W-1:0]       move_count_q;
  logic                   board_full_q;
  logic                   col_ready_q;

  logic [HGT_W-1:0]       sel_height_c;
  logic                   col_legal_c;
  logic                   col_full_c;
  logic [IDX_W-1:0]       place_idx_c;

`ifdef COLUMN_DROP_UNDO_EN
  logic                   undo_avail_q;
  logic                   undo_ack_q;
  logic                   undo_go_c;
  logic [IDX_W-1:0]       undo_idx_c;
`endif

  // Height of the latched column; columns outside the board read as empty.
  always_comb begin
    sel_height_c = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_q == COL_W'(c)) sel_height_c = height_q[c];
    end
  end

  // Legality of the latched request and the target cell index.
  always_comb begin
    col_legal_c = ({1'b0, col_q} < (COL_W+1)'(COLS));
    col_full_c  = (sel_height_c == HGT_W'(ROWS));
    place_idx_c = IDX_W'(sel_height_c) * IDX_W'(COLS) + IDX_W'(col_q);
  end

`ifdef COLUMN_DROP_UNDO_EN
  // Undo is taken only while waiting for input and a fresh placement exists.
  always_comb begin
    undo_go_c  = undo_req && undo_avail_q && (move_count_q != '0) &&
                 ((state_q == S_IDLE) || (state_q == S_FULL));
    undo_idx_c = IDX_W'(last_row_q) * IDX_W'(COLS) + IDX_W'(last_col_q);
  end
`endif

  // Move FSM together with board, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      board_p1_q    <= '0;
      board_p2_q    <= '0;
      cur_player_q  <= 1'b0;
      move_ack_q    <= 1'b0;
      move_reject_q <= 1'b0;
      last_row_q    <= '0;
      last_col_q    <= '0;
      move_count_q  <= '0;
      board_full_q  <= 1'b0;
      col_ready_q   <= 1'b1;
      for (int unsigned c = 0; c < COLS; c++) height_q[c] <= '0;
`ifdef COLUMN_DROP_UNDO_EN
      undo_avail_q  <= 1'b0;
      undo_ack_q    <= 1'b0;
`endif
    end else begin
      move_ack_q    <= 1'b0;
      move_reject_q <= 1'b0;
`ifdef COLUMN_DROP_UNDO_EN
      undo_ack_q    <= 1'b0;
`endif
      if (new_game) begin
        // Synchronous restart; any in-flight move is dropped silently.
        state_q      <= S_IDLE;
        col_q        <= '0;
        board_p1_q   <= '0;
        board_p2_q   <= '0;
        cur_player_q <= 1'b0;
        last_row_q   <= '0;
        last_col_q   <= '0;
        move_count_q <= '0;
        board_full_q <= 1'b0;
        col_ready_q  <= 1'b1;
        for (int unsigned c = 0; c < COLS; c++) height_q[c] <= '0;
`ifdef COLUMN_DROP_UNDO_EN
        undo_avail_q <= 1'b0;
`endif
      end
`ifdef COLUMN_DROP_UNDO_EN
      else if (undo_go_c) begin
        // The piece belongs to the player who is not on turn now.
        if (cur_player_q) board_p1_q[undo_idx_c] <= 1'b0;
        else              board_p2_q[undo_idx_c] <= 1'b0;
        for (int unsigned c = 0; c < COLS; c++) begin
          if ((last_col_q == COL_W'(c)) && (height_q[c] != '0))
            height_q[c] <= height_q[c] - HGT_W'(1);
        end
        move_count_q <= move_count_q - CNT_W'(1);
        cur_player_q <= ~cur_player_q;
        board_full_q <= 1'b0;
        undo_avail_q <= 1'b0;
        undo_ack_q   <= 1'b1;
        col_ready_q  <= 1'b1;
        state_q      <= S_IDLE;
      end
`endif
      else begin
        case (state_q)
          S_IDLE: begin
            if (col_valid) begin
              col_q       <= col_idx;
              col_ready_q <= 1'b0;
              state_q     <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (!col_legal_c || col_full_c) begin
              move_reject_q <= 1'b1;
              col_ready_q   <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              state_q <= S_PLACE;
            end
          end
          S_PLACE: begin
            if (cur_player_q) board_p2_q[place_idx_c] <= 1'b1;
            else              board_p1_q[place_idx_c] <= 1'b1;
            for (int unsigned c = 0; c < COLS; c++) begin
              if ((col_q == COL_W'(c)) && (height_q[c] != HGT_W'(ROWS)))
                height_q[c] <= height_q[c] + HGT_W'(1);
            end
            move_count_q <= move_count_q + CNT_W'(1);
            cur_player_q <= ~cur_player_q;
            last_row_q   <= sel_height_c;
            last_col_q   <= col_q;
            move_ack_q   <= 1'b1;
`ifdef COLUMN_DROP_UNDO_EN
            undo_avail_q <= 1'b1;
`endif
            if (move_count_q == CNT_W'(CELLS - 1)) begin
              board_full_q <= 1'b1;
              state_q      <= S_FULL;
            end else begin
              col_ready_q  <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
          S_FULL: begin
            col_ready_q <= 1'b0;
          end
          default: begin
            col_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign col_ready   = col_ready_q;
  assign move_ack    = move_ack_q;
  assign move_reject = move_reject_q;
  assign cur_player  = cur_player_q;
  assign board_p1    = board_p1_q;
  assign board_p2    = board_p2_q;
  assign last_row    = last_row_q;
  assign last_col    = last_col_q;
  assign move_count  = move_count_q;
  assign board_full  = board_full_q;
`ifdef COLUMN_DROP_UNDO_EN
  assign undo_ack    = undo_ack_q;
`endif

endmodule
